// File: rtl/switch_matrix_cfg_if.sv
// Configuration and readback port of the switch box. The controller drives the
// master side; the switch box exposes the slave side.
interface switch_matrix_cfg_if #(
  parameter int W_TB = 5,
  parameter int W_LR = 4
);
  localparam int N     = 2 * W_TB + 2 * W_LR;
  localparam int WMAX  = (W_TB > W_LR) ? W_TB : W_LR;
  localparam int IDX_W = $clog2(WMAX);
  localparam int AW    = $clog2(N);
  localparam int CW    = 3 + IDX_W;

  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_data;
  logic          cfg_commit;
  logic          cfg_clear;
  logic          cfg_done;
  logic          cfg_err;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_data;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_commit, cfg_clear, rd_addr,
    input  cfg_ready, cfg_done, cfg_err, rd_data
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_commit, cfg_clear, rd_addr,
    output cfg_ready, cfg_done, cfg_err, rd_data
  );
endinterface

// File: rtl/switch_matrix_cfg.sv
// Double-buffered routing switch box: writes land in a shadow table, a commit
// copies it atomically into the active table that steers the combinational pins.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | accepting writes; commit or clear requests are sampled here
//   S_COMMIT | one cycle: active table <= shadow table, pulse cfg_done
//   S_CLEAR  | N cycles: zero one shadow entry per cycle, then pulse cfg_done
module switch_matrix_cfg #(
  parameter int W_TB = 5,
  parameter int W_LR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_TB-1:0]  top_i,
  input  logic [W_TB-1:0]  bottom_i,
  input  logic [W_LR-1:0]  right_i,
  input  logic [W_LR-1:0]  left_i,
  output logic [W_TB-1:0]  top_o,
  output logic [W_TB-1:0]  top_oe,
  output logic [W_TB-1:0]  bottom_o,
  output logic [W_TB-1:0]  bottom_oe,
  output logic [W_LR-1:0]  right_o,
  output logic [W_LR-1:0]  right_oe,
  output logic [W_LR-1:0]  left_o,
  output logic [W_LR-1:0]  left_oe,
  switch_matrix_cfg_if.slave cfg
);
  localparam int N     = 2 * W_TB + 2 * W_LR;
  localparam int WMAX  = (W_TB > W_LR) ? W_TB : W_LR;
  localparam int IDX_W = $clog2(WMAX);
  localparam int AW    = $clog2(N);
  localparam int CW    = 3 + IDX_W;
  localparam int PADW  = 1 << IDX_W;

  localparam logic [AW-1:0]    ADDR_LAST = AW'(N - 1);
  localparam logic [IDX_W-1:0] TB_MAX    = IDX_W'(W_TB - 1);
  localparam logic [IDX_W-1:0] LR_MAX    = IDX_W'(W_LR - 1);

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_CLEAR} state_t;

  state_t           state;
  logic [AW-1:0]    counter;
  logic [CW-1:0]    shadow [N];
  logic [CW-1:0]    active [N];

  logic [2:0]       wr_code;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_legal;
  logic             wr_fire;
  logic [CW-1:0]    rd_next;

  assign cfg.cfg_ready = (state == S_IDLE) && !cfg.cfg_clear;
  assign wr_fire       = cfg.cfg_valid && cfg.cfg_ready;
  assign wr_code       = cfg.cfg_data[2:0];
  assign wr_idx        = cfg.cfg_data[CW-1:3];

  always_comb begin
    wr_legal = 1'b0;
    case (wr_code)
      3'd0:       wr_legal = 1'b1;
      3'd1, 3'd3: wr_legal = (wr_idx <= TB_MAX);
      3'd2, 3'd4: wr_legal = (wr_idx <= LR_MAX);
      default:    wr_legal = 1'b0;
    endcase
    wr_legal = wr_legal && (cfg.cfg_addr <= ADDR_LAST);
  end

  // Out-of-range readback addresses match no entry and return zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < N; i++)
      if (cfg.rd_addr == AW'(i)) rd_next = shadow[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      counter      <= '0;
      cfg.cfg_done <= 1'b0;
      cfg.cfg_err  <= 1'b0;
      cfg.rd_data  <= '0;
      for (int i = 0; i < N; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      cfg.cfg_done <= 1'b0;
      cfg.rd_data  <= rd_next;
      case (state)
        S_IDLE: begin
          if (cfg.cfg_clear) begin
            state   <= S_CLEAR;
            counter <= '0;
          end else begin
            if (wr_fire) begin
              if (wr_legal) begin
                for (int i = 0; i < N; i++)
                  if (cfg.cfg_addr == AW'(i)) shadow[i] <= cfg.cfg_data;
              end else begin
                cfg.cfg_err <= 1'b1;
              end
            end
            if (cfg.cfg_commit) state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          for (int i = 0; i < N; i++) active[i] <= shadow[i];
          cfg.cfg_done <= 1'b1;
          state        <= S_IDLE;
        end
        S_CLEAR: begin
          for (int i = 0; i < N; i++)
            if (counter == AW'(i)) shadow[i] <= '0;
          counter <= counter + 1'b1;
          if (counter == ADDR_LAST) begin
            cfg.cfg_done <= 1'b1;
            cfg.cfg_err  <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Track inputs are zero-padded so an IDX_W-bit index always selects in range.
  logic [PADW-1:0] top_pad, bottom_pad, right_pad, left_pad;
  logic [N-1:0]    route_o, route_oe;

  assign top_pad    = PADW'(top_i);
  assign bottom_pad = PADW'(bottom_i);
  assign right_pad  = PADW'(right_i);
  assign left_pad   = PADW'(left_i);

  always_comb begin
    route_o  = '0;
    route_oe = '0;
    for (int p = 0; p < N; p++) begin
      case (active[p][2:0])
        3'd1: begin route_o[p] = top_pad[active[p][CW-1:3]];    route_oe[p] = 1'b1; end
        3'd2: begin route_o[p] = right_pad[active[p][CW-1:3]];  route_oe[p] = 1'b1; end
        3'd3: begin route_o[p] = bottom_pad[active[p][CW-1:3]]; route_oe[p] = 1'b1; end
        3'd4: begin route_o[p] = left_pad[active[p][CW-1:3]];   route_oe[p] = 1'b1; end
        default: begin route_o[p] = 1'b0; route_oe[p] = 1'b0; end
      endcase
    end
  end

  assign top_o     = route_o[W_TB-1:0];
  assign top_oe    = route_oe[W_TB-1:0];
  assign right_o   = route_o[W_TB +: W_LR];
  assign right_oe  = route_oe[W_TB +: W_LR];
  assign bottom_o  = route_o[W_TB+W_LR +: W_TB];
  assign bottom_oe = route_oe[W_TB+W_LR +: W_TB];
  assign left_o    = route_o[2*W_TB+W_LR +: W_LR];
  assign left_oe   = route_oe[2*W_TB+W_LR +: W_LR];
endmodule

// File: tb/tb_switch_matrix_cfg.sv
// Self-checking bench for switch_matrix_cfg: randomized traffic against a
// table-level model of the shadow/active tables and the routing rules.
module tb_switch_matrix_cfg;
  localparam int W_TB = 5;
  localparam int W_LR = 4;
  localparam int N    = 2 * W_TB + 2 * W_LR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W_TB-1:0] top_i, bottom_i, top_o, top_oe, bottom_o, bottom_oe;
  logic [W_LR-1:0] right_i, left_i, right_o, right_oe, left_o, left_oe;

  switch_matrix_cfg_if #(.W_TB(W_TB), .W_LR(W_LR)) bus ();

  switch_matrix_cfg #(.W_TB(W_TB), .W_LR(W_LR)) dut (
    .clk(clk), .rst(rst),
    .top_i(top_i), .bottom_i(bottom_i), .right_i(right_i), .left_i(left_i),
    .top_o(top_o), .top_oe(top_oe), .bottom_o(bottom_o), .bottom_oe(bottom_oe),
    .right_o(right_o), .right_oe(right_oe), .left_o(left_o), .left_oe(left_oe),
    .cfg(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_shadow [N];
  int m_active [N];
  bit m_err = 1'b0;

  wire [N-1:0] act_o  = {left_o, bottom_o, right_o, top_o};
  wire [N-1:0] act_oe = {left_oe, bottom_oe, right_oe, top_oe};

  function automatic bit legal(int a, int d);
    int code = d % 8;
    int k    = d / 8;
    if (a >= N || code > 4) return 1'b0;
    if (code == 0) return 1'b1;
    return k < (((code == 1) || (code == 3)) ? W_TB : W_LR);
  endfunction

  function automatic logic [N-1:0] exp_o();
    logic [N-1:0] r = '0;
    for (int p = 0; p < N; p++) begin
      int k = m_active[p] / 8;
      case (m_active[p] % 8)
        1: r[p] = ((top_i    >> k) & 5'd1) != 0;
        2: r[p] = ((right_i  >> k) & 4'd1) != 0;
        3: r[p] = ((bottom_i >> k) & 5'd1) != 0;
        4: r[p] = ((left_i   >> k) & 4'd1) != 0;
        default: r[p] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [N-1:0] exp_oe();
    logic [N-1:0] r = '0;
    for (int p = 0; p < N; p++) r[p] = (m_active[p] % 8) != 0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_tracks();
    top_i    = 5'($urandom);
    bottom_i = 5'($urandom);
    right_i  = 4'($urandom);
    left_i   = 4'($urandom);
    #1;
  endtask

  task automatic do_write(int a, int d);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 5'(a);
    bus.cfg_data  = 6'(d);
    tick();
    bus.cfg_valid = 1'b0;
    if (legal(a, d)) m_shadow[a] = d;
    else m_err = 1'b1;
  endtask

  task automatic do_commit();
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    tick();
    m_active = m_shadow;
  endtask

  task automatic do_clear(output bit got);
    bus.cfg_clear = 1'b1;
    tick();
    bus.cfg_clear = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.cfg_done) begin got = 1'b1; break; end
      tick();
    end
    for (int i = 0; i < N; i++) m_shadow[i] = 0;
    m_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rand_tracks();
    tick(); tick();
    rst = 1'b0;
    rand_tracks();
    n_cmp++; if (act_oe !== '0) begin n_bad++; $display("FAIL reset_oe got=%h exp=0", act_oe); end
    n_cmp++; if (act_o !== '0) begin n_bad++; $display("FAIL reset_o got=%h exp=0", act_o); end
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", bus.cfg_ready); end
    n_cmp++; if (bus.cfg_done !== 1'b0 || bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_flags done=%b err=%b exp=0/0", bus.cfg_done, bus.cfg_err); end
    n_cmp++; if (bus.rd_data !== '0) begin n_bad++; $display("FAIL reset_rd got=%h exp=0", bus.rd_data); end
  endtask

  task automatic test_write_no_commit();
    do_write(0, 'h14);
    bus.rd_addr = 5'd0;
    tick();
    n_cmp++; if (bus.rd_data !== 6'h14) begin n_bad++; $display("FAIL wr_readback got=%h exp=14", bus.rd_data); end
    n_cmp++; if (top_oe[0] !== 1'b0) begin n_bad++; $display("FAIL wr_precommit_oe got=%b exp=0", top_oe[0]); end
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    n_cmp++; if (bus.cfg_ready !== 1'b0 || bus.cfg_done !== 1'b0) begin n_bad++; $display("FAIL commit_cycle1 ready=%b done=%b exp=0/0", bus.cfg_ready, bus.cfg_done); end
    n_cmp++; if (top_oe[0] !== 1'b0) begin n_bad++; $display("FAIL commit_cycle1_oe got=%b exp=0", top_oe[0]); end
    tick();
    m_active = m_shadow;
    n_cmp++; if (bus.cfg_done !== 1'b1) begin n_bad++; $display("FAIL commit_done got=%b exp=1", bus.cfg_done); end
    for (int i = 0; i < 4; i++) begin
      rand_tracks();
      n_cmp++; if (top_o[0] !== left_i[2] || top_oe[0] !== 1'b1) begin n_bad++; $display("FAIL route_top0 o=%b oe=%b exp=%b/1", top_o[0], top_oe[0], left_i[2]); end
      n_cmp++; if (act_o !== exp_o() || act_oe !== exp_oe()) begin n_bad++; $display("FAIL route_all o=%h oe=%h exp=%h/%h", act_o, act_oe, exp_o(), exp_oe()); end
    end
    tick();
    n_cmp++; if (bus.cfg_done !== 1'b0) begin n_bad++; $display("FAIL commit_single_pulse got=%b exp=0", bus.cfg_done); end
  endtask

  task automatic test_illegal();
    int addrs [3] = '{18, 1, 2};
    int datas [3] = '{'h14, 'h22, 'h07};
    bit got;
    for (int c = 0; c < 3; c++) begin
      do_write(addrs[c], datas[c]);
      n_cmp++; if (bus.cfg_err !== m_err) begin n_bad++; $display("FAIL illegal_err case=%0d got=%b exp=%b", c, bus.cfg_err, m_err); end
      for (int a = 0; a < N + 2; a++) begin
        bus.rd_addr = 5'(a);
        tick();
        n_cmp++; if (bus.rd_data !== 6'((a < N) ? m_shadow[a] : 0)) begin n_bad++; $display("FAIL illegal_shadow case=%0d addr=%0d got=%h exp=%h", c, a, bus.rd_data, (a < N) ? m_shadow[a] : 0); end
      end
      do_clear(got);
      n_cmp++; if (got !== 1'b1 || bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL illegal_clear done=%b err=%b exp=1/0", got, bus.cfg_err); end
    end
  endtask

  task automatic test_same_cycle();
    bus.cfg_valid  = 1'b1;
    bus.cfg_addr   = 5'd5;
    bus.cfg_data   = 6'h23;
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_valid  = 1'b0;
    bus.cfg_commit = 1'b0;
    m_shadow[5] = 'h23;
    n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL same_ready got=%b exp=0", bus.cfg_ready); end
    tick();
    m_active = m_shadow;
    n_cmp++; if (bus.cfg_done !== 1'b1) begin n_bad++; $display("FAIL same_done got=%b exp=1", bus.cfg_done); end
    for (int i = 0; i < 4; i++) begin
      rand_tracks();
      n_cmp++; if (right_o[0] !== bottom_i[4] || right_oe[0] !== 1'b1) begin n_bad++; $display("FAIL same_route o=%b oe=%b exp=%b/1", right_o[0], right_oe[0], bottom_i[4]); end
      n_cmp++; if (act_o !== exp_o() || act_oe !== exp_oe()) begin n_bad++; $display("FAIL same_all o=%h oe=%h exp=%h/%h", act_o, act_oe, exp_o(), exp_oe()); end
    end
  endtask

  task automatic test_back_to_back();
    do_write(3, 'h09);
    bus.cfg_commit = 1'b1;
    tick();
    tick();
    bus.cfg_commit = 1'b0;
    m_active = m_shadow;
    n_cmp++; if (bus.cfg_done !== 1'b1) begin n_bad++; $display("FAIL b2b_done got=%b exp=1", bus.cfg_done); end
    n_cmp++; if (act_oe !== exp_oe()) begin n_bad++; $display("FAIL b2b_oe got=%h exp=%h", act_oe, exp_oe()); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.cfg_done !== 1'b0 || bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_no_queue cyc=%0d done=%b ready=%b exp=0/1", i, bus.cfg_done, bus.cfg_ready); end
    end
  endtask

  task automatic test_random();
    bit got;
    for (int i = 0; i < 60; i++) begin
      do_write($urandom_range(0, N + 1), $urandom_range(0, 63));
      n_cmp++; if (bus.cfg_err !== m_err) begin n_bad++; $display("FAIL rand_err it=%0d got=%b exp=%b", i, bus.cfg_err, m_err); end
      if (i % 10 == 9) begin
        do_commit();
        n_cmp++; if (bus.cfg_done !== 1'b1) begin n_bad++; $display("FAIL rand_done it=%0d got=%b exp=1", i, bus.cfg_done); end
        for (int j = 0; j < 3; j++) begin
          rand_tracks();
          n_cmp++; if (act_o !== exp_o() || act_oe !== exp_oe()) begin n_bad++; $display("FAIL rand_route it=%0d o=%h oe=%h exp=%h/%h", i, act_o, act_oe, exp_o(), exp_oe()); end
        end
      end
      if (i == 29) do_clear(got);
    end
    for (int a = 0; a < N + 2; a++) begin
      bus.rd_addr = 5'(a);
      tick();
      n_cmp++; if (bus.rd_data !== 6'((a < N) ? m_shadow[a] : 0)) begin n_bad++; $display("FAIL rand_readback addr=%0d got=%h exp=%h", a, bus.rd_data, (a < N) ? m_shadow[a] : 0); end
    end
  endtask

  task automatic test_clear();
    do_write(9, 'h1A);
    do_write(16, 'h0C);
    do_commit();
    do_write(0, 'h07);
    rand_tracks();
    n_cmp++; if (bus.cfg_err !== 1'b1) begin n_bad++; $display("FAIL clear_pre_err got=%b exp=1", bus.cfg_err); end
    bus.cfg_clear = 1'b1;
    tick();
    bus.cfg_clear = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_cmp++; if (bus.cfg_ready !== 1'b0 || bus.cfg_done !== 1'b0) begin n_bad++; $display("FAIL clear_busy cyc=%0d ready=%b done=%b exp=0/0", i, bus.cfg_ready, bus.cfg_done); end
      tick();
    end
    for (int i = 0; i < N; i++) m_shadow[i] = 0;
    m_err = 1'b0;
    n_cmp++; if (bus.cfg_done !== 1'b1 || bus.cfg_err !== 1'b0 || bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL clear_end done=%b err=%b ready=%b exp=1/0/1", bus.cfg_done, bus.cfg_err, bus.cfg_ready); end
    n_cmp++; if (act_o !== exp_o() || act_oe !== exp_oe()) begin n_bad++; $display("FAIL clear_route_kept o=%h oe=%h exp=%h/%h", act_o, act_oe, exp_o(), exp_oe()); end
    for (int a = 0; a < N; a++) begin
      bus.rd_addr = 5'(a);
      tick();
      n_cmp++; if (bus.rd_data !== 6'(m_shadow[a])) begin n_bad++; $display("FAIL clear_shadow addr=%0d got=%h exp=%h", a, bus.rd_data, m_shadow[a]); end
    end
    do_commit();
    n_cmp++; if (act_oe !== '0 || act_o !== '0) begin n_bad++; $display("FAIL clear_commit o=%h oe=%h exp=0/0", act_o, act_oe); end
  endtask

  task automatic test_reset_mid_clear();
    do_write(7, 'h09);
    do_commit();
    bus.cfg_clear = 1'b1;
    tick();
    bus.cfg_clear = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
    m_err = 1'b0;
    rand_tracks();
    n_cmp++; if (bus.cfg_ready !== 1'b1 || bus.cfg_done !== 1'b0) begin n_bad++; $display("FAIL rstclr_state ready=%b done=%b exp=1/0", bus.cfg_ready, bus.cfg_done); end
    n_cmp++; if (act_oe !== exp_oe() || act_o !== exp_o()) begin n_bad++; $display("FAIL rstclr_route o=%h oe=%h exp=%h/%h", act_o, act_oe, exp_o(), exp_oe()); end
    for (int a = 0; a < N; a++) begin
      bus.rd_addr = 5'(a);
      tick();
      n_cmp++; if (bus.rd_data !== 6'(m_shadow[a]) || bus.cfg_done !== 1'b0) begin n_bad++; $display("FAIL rstclr_table addr=%0d rd=%h done=%b exp=%h/0", a, bus.rd_data, bus.cfg_done, m_shadow[a]); end
    end
  endtask

  initial begin
    bus.cfg_valid  = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.cfg_commit = 1'b0;
    bus.cfg_clear  = 1'b0;
    bus.rd_addr    = '0;
    top_i = '0; bottom_i = '0; right_i = '0; left_i = '0;
    test_reset();
    test_write_no_commit();
    test_illegal();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
